// File: rtl/updtx_sched_pkg.sv
// Shared types for the USBPD TX scheduler: FSM state encoding and the
// outcome code that the FIN state reports.
package updtx_sched_pkg;

    // Encoding is visible on sch_fsm for debug, so keep these values stable.
    typedef enum logic [2:0] {
        SCH_IDLE = 3'd0,
        SCH_GAP  = 3'd1,
        SCH_SEND = 3'd2,
        SCH_CRCW = 3'd3,
        SCH_FIN  = 3'd4
    } sch_state_e;

    // Outcome latched on the way into FIN and pulsed for one cycle there.
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_DONE = 2'd1,
        RES_FAIL = 2'd2,
        RES_DISC = 2'd3
    } sch_res_e;

endpackage

// File: rtl/updtx_sched_if.sv
// Bundle between the register block / PHY and the TX scheduler.
// Signalling: r_txreq, r_hrreq, ptx_ack, prx_gdcrc and prx_gdmsgrcvd are
// single-cycle pulses sampled on the rising clock edge, with no backpressure.
// sch_txreq is a level the PHY sees until it answers with ptx_ack; the
// scheduler drops it combinationally in the ack cycle. sch_done, sch_fail,
// sch_disc and sch_ovr are single-cycle pulses.
interface updtx_sched_if;
    logic       r_txreq;
    logic       r_hrreq;
    logic [1:0] r_nretry;
    logic [2:0] r_msgid;
    logic       pid_ccidle;
    logic       ptx_ack;
    logic       prx_gdcrc;
    logic [2:0] prx_gdcrc_id;
    logic       prx_gdmsgrcvd;
    logic       sch_txreq;
    logic       sch_hrst;
    logic       sch_busy;
    logic       sch_done;
    logic       sch_fail;
    logic       sch_disc;
    logic       sch_ovr;
    logic [1:0] sch_rtycnt;
    logic [2:0] sch_fsm;

    modport slave (
        input  r_txreq, r_hrreq, r_nretry, r_msgid,
        input  pid_ccidle, ptx_ack, prx_gdcrc, prx_gdcrc_id, prx_gdmsgrcvd,
        output sch_txreq, sch_hrst, sch_busy, sch_done, sch_fail,
        output sch_disc, sch_ovr, sch_rtycnt, sch_fsm
    );

    modport master (
        output r_txreq, r_hrreq, r_nretry, r_msgid,
        output pid_ccidle, ptx_ack, prx_gdcrc, prx_gdcrc_id, prx_gdmsgrcvd,
        input  sch_txreq, sch_hrst, sch_busy, sch_done, sch_fail,
        input  sch_disc, sch_ovr, sch_rtycnt, sch_fsm
    );
endinterface

// File: rtl/updtx_sched_tmr.sv
// Loadable saturating down-counter shared by the inter-frame gap and the
// CRCReceiveTimer (the two phases never overlap).
module updtx_sched_tmr #(
    parameter int NBT = 14
) (
    input  logic           clk,
    input  logic           srstz,
    input  logic           i_ld,
    input  logic [NBT-1:0] i_ldval,
    input  logic           i_en,
    output logic           o_zero
);
    logic [NBT-1:0] r_cnt;

    // Load has priority; counting stops at zero instead of wrapping.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ldval;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - NBT'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/updtx_sched.sv
// USBPD TX scheduler: arbitrates message and Hard Reset requests, enforces
// the CC-idle inter-frame gap, drives the PHY TX request and runs the
// GoodCRC wait / retry loop for messages.
module updtx_sched
    import updtx_sched_pkg::*;
#(
    parameter int GAP_CYC = 300,
    parameter int CRC_CYC = 12000,
    parameter int TMR_NBT = 14
) (
    input logic          clk,
    input logic          srstz,
    updtx_sched_if.slave sch
);
    // The timer is loaded with N-1 because the first cycle in the new state
    // already counts, so GAP lasts GAP_CYC idle cycles and CRCW lasts CRC_CYC.
    localparam logic [TMR_NBT-1:0] GAP_LD = TMR_NBT'(GAP_CYC - 1);
    localparam logic [TMR_NBT-1:0] CRC_LD = TMR_NBT'(CRC_CYC - 1);

    sch_state_e         r_state;
    sch_state_e         w_nxt_state;
    logic               r_hr;
    logic               w_nxt_hr;
    logic               r_pend_hr;
    logic               w_nxt_pend;
    logic [1:0]         r_rtycnt;
    logic [1:0]         w_nxt_rty;
    sch_res_e           r_res;
    sch_res_e           w_nxt_res;
    logic               w_tmr_ld;
    logic [TMR_NBT-1:0] w_tmr_ldval;
    logic               w_tmr_en;
    logic               w_tmr_zero;
    logic               w_hr_evt;
    logic               w_gdcrc_ok;
    logic               w_ovr;

    // A Hard Reset is wanted either right now or from an earlier latched request.
    assign w_hr_evt   = sch.r_hrreq | r_pend_hr;
    assign w_gdcrc_ok = sch.prx_gdcrc & (sch.prx_gdcrc_id == sch.r_msgid);

    updtx_sched_tmr #(
        .NBT (TMR_NBT)
    ) u_tmr (
        .clk     (clk),
        .srstz   (srstz),
        .i_ld    (w_tmr_ld),
        .i_ldval (w_tmr_ldval),
        .i_en    (w_tmr_en),
        .o_zero  (w_tmr_zero)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            r_state   <= SCH_IDLE;
            r_hr      <= 1'b0;
            r_pend_hr <= 1'b0;
            r_rtycnt  <= 2'd0;
            r_res     <= RES_NONE;
        end else begin
            r_state   <= w_nxt_state;
            r_hr      <= w_nxt_hr;
            r_pend_hr <= w_nxt_pend;
            r_rtycnt  <= w_nxt_rty;
            r_res     <= w_nxt_res;
        end
    end

    // Next-state logic, timer control and overrun detection.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_hr    = r_hr;
        // A Hard Reset arriving while a message is in flight is remembered.
        w_nxt_pend  = r_pend_hr | (sch.r_hrreq & (r_state != SCH_IDLE) & ~r_hr);
        w_nxt_rty   = r_rtycnt;
        w_nxt_res   = r_res;
        w_tmr_ld    = 1'b0;
        w_tmr_ldval = GAP_LD;
        w_tmr_en    = 1'b0;
        w_ovr       = sch.r_txreq & ((r_state != SCH_IDLE) | w_hr_evt);

        unique case (r_state)
            SCH_IDLE: begin
                if (w_hr_evt) begin
                    w_nxt_state = SCH_GAP;
                    w_nxt_hr    = 1'b1;
                    w_nxt_pend  = 1'b0;
                    w_tmr_ld    = 1'b1;
                end else if (sch.r_txreq) begin
                    w_nxt_state = SCH_GAP;
                    w_nxt_hr    = 1'b0;
                    w_nxt_rty   = 2'd0;
                    w_tmr_ld    = 1'b1;
                end
            end
            SCH_GAP: begin
                w_tmr_en = sch.pid_ccidle;
                if (!r_hr && w_hr_evt) begin
                    // Message pre-empted: restart the gap for the Hard Reset.
                    w_nxt_hr   = 1'b1;
                    w_nxt_pend = 1'b0;
                    w_tmr_ld   = 1'b1;
                end else if (!r_hr && sch.prx_gdmsgrcvd) begin
                    w_nxt_state = SCH_FIN;
                    w_nxt_res   = RES_DISC;
                end else if (!sch.pid_ccidle) begin
                    w_tmr_ld = 1'b1;
                end else if (w_tmr_zero) begin
                    w_nxt_state = SCH_SEND;
                end
            end
            SCH_SEND: begin
                if (sch.ptx_ack) begin
                    if (r_hr) begin
                        w_nxt_state = SCH_FIN;
                        w_nxt_res   = RES_DONE;
                    end else if (w_hr_evt) begin
                        w_nxt_state = SCH_GAP;
                        w_nxt_hr    = 1'b1;
                        w_nxt_pend  = 1'b0;
                        w_tmr_ld    = 1'b1;
                    end else begin
                        w_nxt_state = SCH_CRCW;
                        w_tmr_ld    = 1'b1;
                        w_tmr_ldval = CRC_LD;
                    end
                end
            end
            SCH_CRCW: begin
                w_tmr_en = 1'b1;
                if (w_hr_evt) begin
                    w_nxt_state = SCH_GAP;
                    w_nxt_hr    = 1'b1;
                    w_nxt_pend  = 1'b0;
                    w_tmr_ld    = 1'b1;
                end else if (w_gdcrc_ok) begin
                    w_nxt_state = SCH_FIN;
                    w_nxt_res   = RES_DONE;
                end else if (sch.prx_gdmsgrcvd) begin
                    w_nxt_state = SCH_FIN;
                    w_nxt_res   = RES_DISC;
                end else if (w_tmr_zero) begin
                    if (r_rtycnt < sch.r_nretry) begin
                        w_nxt_rty   = r_rtycnt + 2'd1;
                        w_nxt_state = SCH_GAP;
                        w_tmr_ld    = 1'b1;
                    end else begin
                        w_nxt_state = SCH_FIN;
                        w_nxt_res   = RES_FAIL;
                    end
                end
            end
            SCH_FIN: begin
                w_nxt_state = SCH_IDLE;
            end
            default: begin
                w_nxt_state = SCH_IDLE;
            end
        endcase
    end

    // TX request drops in the ack cycle itself so the PHY never sees a second frame.
    assign sch.sch_txreq  = (r_state == SCH_SEND) & ~sch.ptx_ack;
    assign sch.sch_hrst   = (r_state == SCH_SEND) & r_hr;
    assign sch.sch_busy   = (r_state != SCH_IDLE);
    assign sch.sch_done   = (r_state == SCH_FIN) & (r_res == RES_DONE);
    assign sch.sch_fail   = (r_state == SCH_FIN) & (r_res == RES_FAIL);
    assign sch.sch_disc   = (r_state == SCH_FIN) & (r_res == RES_DISC);
    assign sch.sch_ovr    = w_ovr;
    assign sch.sch_rtycnt = r_rtycnt;
    assign sch.sch_fsm    = r_state;
endmodule

// File: tb/tb_updtx_sched.sv
// Directed bench for updtx_sched. A timeline model fills per-cycle expected
// outputs from the scheduling rules (gap length, CRC window, retry count),
// a compare process checks every cycle, and an outcome queue checks the
// order of done/fail/disc reports.
module tb_updtx_sched;
    localparam int G  = 20;
    localparam int C  = 100;
    localparam int NC = 1110;

    logic clk;
    logic srstz;
    int   total;
    int   bad;
    int   cyc;
    bit   run;

    updtx_sched_if sif ();

    updtx_sched #(
        .GAP_CYC (G),
        .CRC_CYC (C),
        .TMR_NBT (14)
    ) dut (
        .clk   (clk),
        .srstz (srstz),
        .sch   (sif)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus tables ----------------
    bit         s_txreq[NC];
    bit         s_hrreq[NC];
    bit         s_ack[NC];
    bit         s_gdcrc[NC];
    bit         s_msgrcvd[NC];
    bit         s_ccidle[NC];
    bit         s_rst[NC];
    logic [2:0] s_gdid[NC];
    logic [2:0] s_msgid[NC];
    logic [1:0] s_nretry[NC];

    // ---------------- expected timeline ----------------
    bit         e_txreq[NC];
    bit         e_hrst[NC];
    bit         e_busy[NC];
    bit         e_done[NC];
    bit         e_fail[NC];
    bit         e_disc[NC];
    bit         e_ovr[NC];
    logic [1:0] e_rty[NC];
    logic [3:0] exp_q[$];   // outcome codes: 1 done, 2 fail, 3 disc

    // Hand-computed pins: cycle, signal id, value.
    // ids: 0 txreq 1 hrst 2 busy 3 done 4 fail 5 disc 6 ovr 7 rtycnt
    int pin_c[19] = '{25, 26, 28, 29, 36, 174, 420, 420, 471, 472, 551, 555, 601, 620, 784, 1065, 1066, 1066, 1101};
    int pin_s[19] = '{ 0,  0,  0,  0,  3,   7,   4,   7,   0,   0,   1,   3,   5,   6,   3,    0,    0,    2,    3};
    int pin_v[19] = '{ 0,  1,  1,  0,  1,   1,   1,   2,   0,   1,   1,   1,   1,   1,   1,    1,    0,    0,    1};

    task automatic chk(input string nm, input int k, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, k, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_sig(input int id);
        case (id)
            0:       return 4'(sif.sch_txreq);
            1:       return 4'(sif.sch_hrst);
            2:       return 4'(sif.sch_busy);
            3:       return 4'(sif.sch_done);
            4:       return 4'(sif.sch_fail);
            5:       return 4'(sif.sch_disc);
            6:       return 4'(sif.sch_ovr);
            default: return 4'(sif.sch_rtycnt);
        endcase
    endfunction

    // ---------------- model helpers ----------------
    task automatic rty_from(input int t, input logic [1:0] v);
        for (int i = t; i < NC; i++) e_rty[i] = v;
    endtask

    // Message request at cycle t; retry counter reads 0 from the next cycle.
    task automatic m_req(input int t, input logic [2:0] id, input logic [1:0] nr);
        s_txreq[t] = 1'b1;
        for (int i = t; i < NC; i++) begin
            s_msgid[i]  = id;
            s_nretry[i] = nr;
        end
        rty_from(t + 1, 2'd0);
    endtask

    // Gap entered at 'entry' with CC idle throughout: TX after G idle cycles,
    // PHY acks 'dly' cycles after the request rises.
    task automatic m_frame(input int entry, input int dly, input bit hr, output int ack);
        int tx;
        tx  = entry + G;
        ack = tx + dly;
        for (int i = tx; i < ack; i++) e_txreq[i] = 1'b1;
        for (int i = tx; i <= ack; i++) e_hrst[i] = hr;
        s_ack[ack] = 1'b1;
    endtask

    task automatic m_fin(input int t, input int code, input int busy_from);
        for (int i = busy_from; i <= t; i++) e_busy[i] = 1'b1;
        case (code)
            1:       e_done[t] = 1'b1;
            2:       e_fail[t] = 1'b1;
            default: e_disc[t] = 1'b1;
        endcase
        exp_q.push_back(4'(code));
    endtask

    task automatic gdcrc_at(input int t, input logic [2:0] id);
        s_gdcrc[t] = 1'b1;
        s_gdid[t]  = id;
    endtask

    task automatic build();
        int a;
        int entry;
        for (int i = 0; i < NC; i++) begin
            s_ccidle[i] = 1'b1;
            s_gdid[i]   = 3'd0;
            s_msgid[i]  = 3'd0;
            s_nretry[i] = 2'd0;
            e_rty[i]    = 2'd0;
        end
        // 1: plain message id 5, wrong-id GoodCRC ignored, matching one completes
        m_req(5, 3'd5, 2'd0);
        m_frame(6, 3, 1'b0, a);
        gdcrc_at(a + 4, 3'd4);
        gdcrc_at(a + 6, 3'd5);
        m_fin(a + 7, 1, 6);
        // 2: no GoodCRC, two retries then fail
        m_req(50, 3'd1, 2'd2);
        entry = 51;
        for (int r = 0; r <= 2; r++) begin
            m_frame(entry, 2, 1'b0, a);
            if (r < 2) begin
                entry = a + C + 1;
                rty_from(entry, 2'(r + 1));
            end else begin
                m_fin(a + C + 1, 2, 51);
            end
        end
        // 3: CC busy for one cycle 10 cycles before the gap would end
        m_req(440, 3'd2, 2'd0);
        s_ccidle[451] = 1'b0;
        m_frame(452, 2, 1'b0, a);
        gdcrc_at(a + 6, 3'd2);
        m_fin(a + 7, 1, 441);
        // 4: Hard Reset request during CRC wait; second request during HR ignored
        m_req(500, 3'd3, 2'd0);
        m_frame(501, 2, 1'b0, a);
        s_hrreq[530] = 1'b1;
        s_hrreq[540] = 1'b1;
        m_frame(531, 3, 1'b1, a);
        m_fin(a + 1, 1, 501);
        gdcrc_at(560, 3'd3);
        // 5a: incoming message during CRC wait discards; txreq while busy overruns
        m_req(570, 3'd4, 2'd0);
        m_frame(571, 2, 1'b0, a);
        s_txreq[580] = 1'b1;
        e_ovr[580]   = 1'b1;
        s_msgrcvd[600] = 1'b1;
        m_fin(601, 3, 571);
        // 5b: txreq and hrreq together: Hard Reset wins, message overruns
        s_txreq[620] = 1'b1;
        s_hrreq[620] = 1'b1;
        e_ovr[620]   = 1'b1;
        s_msgrcvd[630] = 1'b1;
        m_frame(621, 2, 1'b1, a);
        m_fin(a + 1, 1, 621);
        // 5c: GoodCRC in the very cycle the CRC timer expires, no retries left
        m_req(660, 3'd6, 2'd0);
        m_frame(661, 2, 1'b0, a);
        gdcrc_at(a + C, 3'd6);
        m_fin(a + C + 1, 1, 661);
        // 5d: Hard Reset during a message gap restarts the gap
        m_req(800, 3'd7, 2'd0);
        s_hrreq[810] = 1'b1;
        m_frame(811, 2, 1'b1, a);
        m_fin(a + 1, 1, 801);
        // 5e: Hard Reset during a message frame waits for its ack
        m_req(850, 3'd0, 2'd0);
        m_frame(851, 4, 1'b0, a);
        s_hrreq[872] = 1'b1;
        m_frame(a + 1, 2, 1'b1, a);
        m_fin(a + 1, 1, 851);
        // 6: reset while the retried frame is on the wire, then a fresh message
        m_req(920, 3'd1, 2'd1);
        m_frame(921, 2, 1'b0, a);
        entry = a + C + 1;
        rty_from(entry, 2'd1);
        for (int i = entry + G; i <= 1065; i++) e_txreq[i] = 1'b1;
        for (int i = 921; i <= 1065; i++) e_busy[i] = 1'b1;
        s_rst[1066] = 1'b1;
        s_rst[1067] = 1'b1;
        rty_from(1066, 2'd0);
        m_req(1075, 3'd1, 2'd1);
        m_frame(1076, 2, 1'b0, a);
        gdcrc_at(a + 2, 3'd1);
        m_fin(a + 3, 1, 1076);
    endtask

    // ---------------- compare process ----------------
    always begin
        @(negedge clk);
        #1;
        if (run) begin
            chk("txreq", cyc, 4'(sif.sch_txreq), 4'(e_txreq[cyc]));
            chk("hrst",  cyc, 4'(sif.sch_hrst),  4'(e_hrst[cyc]));
            chk("busy",  cyc, 4'(sif.sch_busy),  4'(e_busy[cyc]));
            chk("done",  cyc, 4'(sif.sch_done),  4'(e_done[cyc]));
            chk("fail",  cyc, 4'(sif.sch_fail),  4'(e_fail[cyc]));
            chk("disc",  cyc, 4'(sif.sch_disc),  4'(e_disc[cyc]));
            chk("ovr",   cyc, 4'(sif.sch_ovr),   4'(e_ovr[cyc]));
            chk("rtycnt", cyc, 4'(sif.sch_rtycnt), 4'(e_rty[cyc]));
            if (e_busy[cyc]) chk("fsm_busy", cyc, 4'(sif.sch_fsm != 3'd0), 4'd1);
            else             chk("fsm_idle", cyc, 4'(sif.sch_fsm), 4'd0);
            for (int p = 0; p < 19; p++) begin
                if (pin_c[p] == cyc) chk("pin", cyc, dut_sig(pin_s[p]), 4'(pin_v[p]));
            end
            if (sif.sch_done || sif.sch_fail || sif.sch_disc) begin
                logic [3:0] code;
                code = sif.sch_done ? 4'd1 : (sif.sch_fail ? 4'd2 : 4'd3);
                if (exp_q.size() == 0) chk("outcome_unexpected", cyc, code, 4'd0);
                else                   chk("outcome", cyc, code, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        run   = 1'b0;
        srstz = 1'b0;
        sif.r_txreq       = 1'b0;
        sif.r_hrreq       = 1'b0;
        sif.r_nretry      = 2'd0;
        sif.r_msgid       = 3'd0;
        sif.pid_ccidle    = 1'b1;
        sif.ptx_ack       = 1'b0;
        sif.prx_gdcrc     = 1'b0;
        sif.prx_gdcrc_id  = 3'd0;
        sif.prx_gdmsgrcvd = 1'b0;
        build();
        #23;
        chk("rst_txreq",  -1, 4'(sif.sch_txreq),  4'd0);
        chk("rst_hrst",   -1, 4'(sif.sch_hrst),   4'd0);
        chk("rst_busy",   -1, 4'(sif.sch_busy),   4'd0);
        chk("rst_done",   -1, 4'(sif.sch_done),   4'd0);
        chk("rst_fail",   -1, 4'(sif.sch_fail),   4'd0);
        chk("rst_disc",   -1, 4'(sif.sch_disc),   4'd0);
        chk("rst_ovr",    -1, 4'(sif.sch_ovr),    4'd0);
        chk("rst_rtycnt", -1, 4'(sif.sch_rtycnt), 4'd0);
        chk("rst_fsm",    -1, 4'(sif.sch_fsm),    4'd0);
        for (int k = 0; k < NC; k++) begin
            @(negedge clk);
            cyc   = k;
            run   = 1'b1;
            srstz = ~s_rst[k];
            sif.r_txreq       = s_txreq[k];
            sif.r_hrreq       = s_hrreq[k];
            sif.r_nretry      = s_nretry[k];
            sif.r_msgid       = s_msgid[k];
            sif.pid_ccidle    = s_ccidle[k];
            sif.ptx_ack       = s_ack[k];
            sif.prx_gdcrc     = s_gdcrc[k];
            sif.prx_gdcrc_id  = s_gdid[k];
            sif.prx_gdmsgrcvd = s_msgrcvd[k];
        end
        #2;
        run = 1'b0;
        chk("outcomes_left", NC, 4'(exp_q.size()), 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
